// File: rtl/sys_defs.sv
// Shared retire-stage types, sizes and the branch mispredict check.
// Latency: not applicable (types, constants and a pure function).
// Backpressure: not applicable.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV
`define N                 4
`define PHYS_REG_SZ_R10K  64
`define ARCH_REG_SZ       32
`define ZERO_REG          5'd0

package sys_defs;
   localparam int ROB_IDX_W  = 5;
   localparam int ARCH_IDX_W = $clog2(`ARCH_REG_SZ);
   localparam int PHYS_IDX_W = $clog2(`PHYS_REG_SZ_R10K);
   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 32;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      RECOVER = 2'd1,
      HALTED  = 2'd2
   } RETIRE_STATE;

   typedef struct packed {
      logic [ADDR_W-1:0]     pc;
      logic [PHYS_IDX_W-1:0] phys_rd;
      logic [PHYS_IDX_W-1:0] prev_phys_rd;
      logic [ARCH_IDX_W-1:0] arch_rd;
      logic                  complete;
      logic                  is_branch;
      logic                  pred_taken;
      logic [ADDR_W-1:0]     pred_target;
      logic                  branch_taken;
      logic [ADDR_W-1:0]     branch_target;
      logic                  halt;
      logic                  illegal;
   } ROB_ENTRY;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] pc;
      logic              taken;
      logic [ADDR_W-1:0] target;
      logic              mispredict;
   } BP_TRAIN_REQUEST;

   typedef struct packed {
      logic [ADDR_W-1:0]     NPC;
      logic [DATA_W-1:0]     data;
      logic [ARCH_IDX_W-1:0] reg_idx;
      logic                  halt;
      logic                  illegal;
      logic                  valid;
   } COMMIT_PACKET;

   // A branch is mispredicted on a wrong direction, or on a taken branch whose target differs.
   function automatic logic is_mispredict(input ROB_ENTRY e);
      return e.is_branch &&
             ((e.pred_taken != e.branch_taken) ||
              (e.branch_taken && (e.pred_target != e.branch_target)));
   endfunction
endpackage
`endif

// File: rtl/retire_select.sv
// Picks the in-order commit prefix of the ROB head window and maps committed branches to train slots.
// Latency: purely combinational.
// Backpressure: enable low commits nothing; the prefix stops at the first lane that cannot retire.
module retire_select
   import sys_defs::*;
#(
   parameter  int N           = `N,
   parameter  int TRAIN_PORTS = 2,
   localparam int POP_W       = $clog2(N + 1),
   localparam int LANE_W      = (N > 1) ? $clog2(N) : 1
)
(
   input  logic                   enable,
   input  ROB_ENTRY [N-1:0]       head_entries,
   input  logic [N-1:0]           head_valids,
   output logic [N-1:0]           commit_mask,
   output logic [POP_W-1:0]       pop_count,
   output logic [TRAIN_PORTS-1:0] slot_vld,
   output logic [LANE_W-1:0]      slot_lane [TRAIN_PORTS],
   output logic                   mis_vld,
   output logic [LANE_W-1:0]      mis_lane,
   output logic                   stop_vld
);
   logic done;
   int   nbr;
   int   ncommit;

   // Walk lanes oldest-first; excluded stoppers end the prefix before the lane, included ones after it.
   always_comb begin
      commit_mask = '0;
      slot_vld    = '0;
      for (int k = 0; k < TRAIN_PORTS; k++) slot_lane[k] = '0;
      mis_vld  = 1'b0;
      mis_lane = '0;
      stop_vld = 1'b0;
      done     = !enable;
      nbr      = 0;
      ncommit  = 0;
      for (int i = 0; i < N; i++) begin
         if (!done) begin
            if (!head_valids[i] || !head_entries[i].complete) begin
               done = 1'b1;
            end else if (head_entries[i].is_branch && (nbr == TRAIN_PORTS)) begin
               done = 1'b1;
            end else begin
               commit_mask[i] = 1'b1;
               ncommit        = ncommit + 1;
               if (head_entries[i].is_branch) begin
                  for (int k = 0; k < TRAIN_PORTS; k++) begin
                     if (k == nbr) begin
                        slot_vld[k]  = 1'b1;
                        slot_lane[k] = LANE_W'(i);
                     end
                  end
                  nbr = nbr + 1;
               end
               if (is_mispredict(head_entries[i])) begin
                  mis_vld  = 1'b1;
                  mis_lane = LANE_W'(i);
                  done     = 1'b1;
               end
               if (head_entries[i].halt || head_entries[i].illegal) begin
                  stop_vld = 1'b1;
                  done     = 1'b1;
               end
            end
         end
      end
      pop_count = POP_W'(ncommit);
   end
endmodule

// File: rtl/retire_unit_mw.sv
// Retires up to N ROB head entries per cycle: arch map writes, free list, checkpoint, predictor training, recovery.
// Latency: rob_pop_count is combinational; every other output is registered one cycle after the commit decision.
// Backpressure: none accepted; RECOVER and HALTED hold rob_pop_count at zero.
module retire_unit_mw
   import sys_defs::*;
#(
   parameter  int N              = `N,
   parameter  int PHYS_REGS      = `PHYS_REG_SZ_R10K,
   parameter  int ARCH_REGS      = `ARCH_REG_SZ,
   parameter  int TRAIN_PORTS    = 2,
   parameter  int RECOVER_CYCLES = 2,
   parameter  int CNT_W          = 32,
   localparam int POP_W          = $clog2(N + 1),
   localparam int LANE_W         = (N > 1) ? $clog2(N) : 1,
   localparam int RC_W           = $clog2(RECOVER_CYCLES + 1)
)
(
   input  logic                                clock,
   input  logic                                reset,
   input  ROB_ENTRY [N-1:0]                    head_entries,
   input  logic [N-1:0]                        head_valids,
   input  logic [N-1:0][ROB_IDX_W-1:0]         head_idxs,
   input  logic [PHYS_REGS-1:0][DATA_W-1:0]    regfile_entries,
   output logic [POP_W-1:0]                    rob_pop_count,
   output logic                                mispredict,
   output logic [ROB_IDX_W-1:0]                rob_mispred_idx,
   output logic [ADDR_W-1:0]                   branch_target_out,
   output logic [PHYS_REGS-1:0]                free_mask,
   output logic [PHYS_REGS-1:0]                freelist_restore_mask,
   output logic [N-1:0]                        arch_write_enables,
   output logic [N-1:0][ARCH_IDX_W-1:0]        arch_write_addrs,
   output logic [N-1:0][PHYS_IDX_W-1:0]        arch_write_phys_regs,
   output BP_TRAIN_REQUEST [TRAIN_PORTS-1:0]   train_req_o,
   output COMMIT_PACKET [N-1:0]                retire_commits_dbg,
   output logic                                halted,
   output logic [CNT_W-1:0]                    commit_count,
   output logic [CNT_W-1:0]                    mispred_count
);
   // Architectural registers start mapped (not free); every other physical register starts free.
   localparam logic [PHYS_REGS-1:0] CKPT_RESET = {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
   localparam logic [CNT_W-1:0]     CNT_MAX    = '1;

   logic [N-1:0]           sel_mask;
   logic [POP_W-1:0]       sel_pop;
   logic [TRAIN_PORTS-1:0] sel_slot_vld;
   logic [LANE_W-1:0]      sel_slot_lane [TRAIN_PORTS];
   logic                   sel_mis_vld;
   logic [LANE_W-1:0]      sel_mis_lane;
   logic                   sel_stop_vld;

   RETIRE_STATE                       state_q, state_d;
   logic [RC_W-1:0]                   rc_q, rc_d;
   logic [PHYS_REGS-1:0]              ckpt_q, ckpt_d;
   logic                              mispredict_q, mispredict_d;
   logic [ROB_IDX_W-1:0]              mis_idx_q, mis_idx_d;
   logic [ADDR_W-1:0]                 btgt_q, btgt_d;
   logic [PHYS_REGS-1:0]              free_q, free_d;
   logic [PHYS_REGS-1:0]              restore_q, restore_d;
   logic [N-1:0]                      we_q, we_d;
   logic [N-1:0][ARCH_IDX_W-1:0]      addrs_q, addrs_d;
   logic [N-1:0][PHYS_IDX_W-1:0]      phys_q, phys_d;
   BP_TRAIN_REQUEST [TRAIN_PORTS-1:0] train_q, train_d;
   COMMIT_PACKET [N-1:0]              dbg_q, dbg_d;
   logic                              halted_q, halted_d;
   logic [CNT_W-1:0]                  ccount_q, ccount_d;
   logic [CNT_W-1:0]                  mcount_q, mcount_d;
   logic [CNT_W:0]                    cc_sum;

   retire_select #(.N(N), .TRAIN_PORTS(TRAIN_PORTS)) u_select (
      .enable       (state_q == RUN),
      .head_entries (head_entries),
      .head_valids  (head_valids),
      .commit_mask  (sel_mask),
      .pop_count    (sel_pop),
      .slot_vld     (sel_slot_vld),
      .slot_lane    (sel_slot_lane),
      .mis_vld      (sel_mis_vld),
      .mis_lane     (sel_mis_lane),
      .stop_vld     (sel_stop_vld)
   );

   assign rob_pop_count = sel_pop;

   // Build next-cycle side effects from the committed lanes and advance the RUN/RECOVER/HALTED FSM.
   always_comb begin
      state_d      = state_q;
      rc_d         = rc_q;
      ckpt_d       = ckpt_q;
      halted_d     = halted_q;
      mispredict_d = 1'b0;
      mis_idx_d    = '0;
      btgt_d       = '0;
      free_d       = '0;
      we_d         = '0;
      addrs_d      = '0;
      phys_d       = '0;
      train_d      = '0;
      dbg_d        = '0;
      for (int i = 0; i < N; i++) begin
         if (sel_mask[i]) begin
            dbg_d[i].valid   = 1'b1;
            dbg_d[i].NPC     = head_entries[i].pc + ADDR_W'(4);
            dbg_d[i].data    = regfile_entries[head_entries[i].phys_rd];
            dbg_d[i].reg_idx = head_entries[i].is_branch ? `ZERO_REG : head_entries[i].arch_rd;
            dbg_d[i].halt    = head_entries[i].halt;
            dbg_d[i].illegal = head_entries[i].illegal;
            if (!head_entries[i].is_branch && (head_entries[i].arch_rd != '0)) begin
               we_d[i]    = 1'b1;
               addrs_d[i] = head_entries[i].arch_rd;
               phys_d[i]  = head_entries[i].phys_rd;
               ckpt_d[head_entries[i].phys_rd] = 1'b0;
               if (head_entries[i].prev_phys_rd != '0) begin
                  free_d[head_entries[i].prev_phys_rd] = 1'b1;
                  ckpt_d[head_entries[i].prev_phys_rd] = 1'b1;
               end
            end
            // Later lanes overwrite, leaving the youngest committed branch.
            if (head_entries[i].is_branch) btgt_d = head_entries[i].branch_target;
         end
      end
      for (int k = 0; k < TRAIN_PORTS; k++) begin
         if (sel_slot_vld[k]) begin
            train_d[k].valid      = 1'b1;
            train_d[k].pc         = head_entries[sel_slot_lane[k]].pc;
            train_d[k].taken      = head_entries[sel_slot_lane[k]].branch_taken;
            train_d[k].target     = head_entries[sel_slot_lane[k]].branch_target;
            train_d[k].mispredict = is_mispredict(head_entries[sel_slot_lane[k]]);
         end
      end
      restore_d = (|sel_mask) ? ckpt_d : '0;
      cc_sum    = {1'b0, ccount_q} + (CNT_W + 1)'(sel_pop);
      ccount_d  = cc_sum[CNT_W] ? CNT_MAX : cc_sum[CNT_W-1:0];
      mcount_d  = mcount_q;
      if (sel_mis_vld) begin
         mispredict_d = 1'b1;
         mis_idx_d    = head_idxs[sel_mis_lane];
         if (mcount_q != CNT_MAX) mcount_d = mcount_q + CNT_W'(1);
      end
      case (state_q)
         RUN: begin
            if (sel_stop_vld) begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end else if (sel_mis_vld) begin
               state_d = RECOVER;
               rc_d    = RC_W'(RECOVER_CYCLES);
            end
         end
         RECOVER: begin
            if (rc_q == RC_W'(1)) begin
               state_d = RUN;
               rc_d    = '0;
            end else begin
               rc_d = rc_q - RC_W'(1);
            end
         end
         default: state_d = HALTED;
      endcase
   end

   // Register FSM, checkpoint, counters and all side-effect outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= RUN;
         rc_q         <= '0;
         ckpt_q       <= CKPT_RESET;
         mispredict_q <= 1'b0;
         mis_idx_q    <= '0;
         btgt_q       <= '0;
         free_q       <= '0;
         restore_q    <= '0;
         we_q         <= '0;
         addrs_q      <= '0;
         phys_q       <= '0;
         train_q      <= '0;
         dbg_q        <= '0;
         halted_q     <= 1'b0;
         ccount_q     <= '0;
         mcount_q     <= '0;
      end else begin
         state_q      <= state_d;
         rc_q         <= rc_d;
         ckpt_q       <= ckpt_d;
         mispredict_q <= mispredict_d;
         mis_idx_q    <= mis_idx_d;
         btgt_q       <= btgt_d;
         free_q       <= free_d;
         restore_q    <= restore_d;
         we_q         <= we_d;
         addrs_q      <= addrs_d;
         phys_q       <= phys_d;
         train_q      <= train_d;
         dbg_q        <= dbg_d;
         halted_q     <= halted_d;
         ccount_q     <= ccount_d;
         mcount_q     <= mcount_d;
      end
   end

   assign mispredict            = mispredict_q;
   assign rob_mispred_idx       = mis_idx_q;
   assign branch_target_out     = btgt_q;
   assign free_mask             = free_q;
   assign freelist_restore_mask = restore_q;
   assign arch_write_enables    = we_q;
   assign arch_write_addrs      = addrs_q;
   assign arch_write_phys_regs  = phys_q;
   assign train_req_o           = train_q;
   assign retire_commits_dbg    = dbg_q;
   assign halted                = halted_q;
   assign commit_count          = ccount_q;
   assign mispred_count         = mcount_q;
endmodule

// File: tb/tb_retire_unit_mw.sv
// Directed and randomized checks of retire_unit_mw against a queue-based retirement model.
// Latency: pop count checked before the edge, registered outputs one cycle later.
// Backpressure: recovery and halt stalls are predicted by the model.
module tb_retire_unit_mw;
   import sys_defs::*;

   localparam int N    = 4;
   localparam int PR   = 64;
   localparam int AR   = 32;
   localparam int TP   = 2;
   localparam int RC   = 2;
   localparam int CW   = 6;
   localparam int CMAX = (1 << CW) - 1;

   logic                           clock;
   logic                           reset;
   ROB_ENTRY [N-1:0]               head_entries;
   logic [N-1:0]                   head_valids;
   logic [N-1:0][ROB_IDX_W-1:0]    head_idxs;
   logic [PR-1:0][DATA_W-1:0]      regfile_entries;
   logic [$clog2(N+1)-1:0]         rob_pop_count;
   logic                           mispredict;
   logic [ROB_IDX_W-1:0]           rob_mispred_idx;
   logic [ADDR_W-1:0]              branch_target_out;
   logic [PR-1:0]                  free_mask;
   logic [PR-1:0]                  freelist_restore_mask;
   logic [N-1:0]                   arch_write_enables;
   logic [N-1:0][ARCH_IDX_W-1:0]   arch_write_addrs;
   logic [N-1:0][PHYS_IDX_W-1:0]   arch_write_phys_regs;
   BP_TRAIN_REQUEST [TP-1:0]       train_req_o;
   COMMIT_PACKET [N-1:0]           retire_commits_dbg;
   logic                           halted;
   logic [CW-1:0]                  commit_count;
   logic [CW-1:0]                  mispred_count;

   retire_unit_mw #(
      .N(N), .PHYS_REGS(PR), .ARCH_REGS(AR), .TRAIN_PORTS(TP),
      .RECOVER_CYCLES(RC), .CNT_W(CW)
   ) dut (
      .clock                 (clock),
      .reset                 (reset),
      .head_entries          (head_entries),
      .head_valids           (head_valids),
      .head_idxs             (head_idxs),
      .regfile_entries       (regfile_entries),
      .rob_pop_count         (rob_pop_count),
      .mispredict            (mispredict),
      .rob_mispred_idx       (rob_mispred_idx),
      .branch_target_out     (branch_target_out),
      .free_mask             (free_mask),
      .freelist_restore_mask (freelist_restore_mask),
      .arch_write_enables    (arch_write_enables),
      .arch_write_addrs      (arch_write_addrs),
      .arch_write_phys_regs  (arch_write_phys_regs),
      .train_req_o           (train_req_o),
      .retire_commits_dbg    (retire_commits_dbg),
      .halted                (halted),
      .commit_count          (commit_count),
      .mispred_count         (mispred_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Reference model state: stall cycles left, halt flag, checkpoint and counters.
   bit            m_halted;
   int            m_block;
   bit [PR-1:0]   m_ckpt;
   int            m_cc;
   int            m_mc;

   int                           e_pop;
   logic                         e_mispredict;
   logic [ROB_IDX_W-1:0]         e_idx;
   logic [ADDR_W-1:0]            e_btgt;
   logic [PR-1:0]                e_free;
   logic [PR-1:0]                e_restore;
   logic [N-1:0]                 e_we;
   logic [N-1:0][ARCH_IDX_W-1:0] e_addrs;
   logic [N-1:0][PHYS_IDX_W-1:0] e_phys;
   BP_TRAIN_REQUEST [TP-1:0]     e_train;
   COMMIT_PACKET [N-1:0]         e_dbg;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ROB_ENTRY alu(input int pc, input int ard, input int prd, input int prev);
      ROB_ENTRY e;
      e              = '0;
      e.pc           = 32'(pc);
      e.arch_rd      = ARCH_IDX_W'(ard);
      e.phys_rd      = PHYS_IDX_W'(prd);
      e.prev_phys_rd = PHYS_IDX_W'(prev);
      e.complete     = 1'b1;
      return e;
   endfunction

   function automatic ROB_ENTRY br(input int pc, input bit pt, input int ptgt, input bit t, input int tgt);
      ROB_ENTRY e;
      e               = '0;
      e.pc            = 32'(pc);
      e.is_branch     = 1'b1;
      e.pred_taken    = pt;
      e.pred_target   = 32'(ptgt);
      e.branch_taken  = t;
      e.branch_target = 32'(tgt);
      e.phys_rd       = PHYS_IDX_W'(pc & 63);
      e.complete      = 1'b1;
      return e;
   endfunction

   function automatic ROB_ENTRY rnd_entry();
      ROB_ENTRY e;
      int r;
      e          = '0;
      e.pc       = $urandom << 2;
      e.complete = ($urandom_range(0, 9) != 0);
      e.phys_rd  = PHYS_IDX_W'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
         r               = $urandom_range(0, 4);
         e.is_branch     = 1'b1;
         e.pred_taken    = 1'($urandom_range(0, 1));
         e.branch_taken  = (r == 0) ? !e.pred_taken : e.pred_taken;
         e.pred_target   = $urandom;
         e.branch_target = (r == 1) ? (e.pred_target ^ 32'h10) : e.pred_target;
      end else begin
         e.arch_rd      = ARCH_IDX_W'($urandom_range(0, 7));
         e.prev_phys_rd = PHYS_IDX_W'($urandom_range(0, 15));
         e.halt         = ($urandom_range(0, 49) == 0);
         e.illegal      = ($urandom_range(0, 49) == 0);
      end
      return e;
   endfunction

   task automatic clear_expect();
      e_pop = 0; e_mispredict = 1'b0; e_idx = '0; e_btgt = '0; e_free = '0; e_restore = '0;
      e_we = '0; e_addrs = '0; e_phys = '0; e_train = '0; e_dbg = '0;
   endtask

   task automatic model_reset();
      m_halted = 1'b0;
      m_block  = 0;
      m_ckpt   = {{(PR - AR){1'b1}}, {AR{1'b0}}};
      m_cc     = 0;
      m_mc     = 0;
      clear_expect();
   endtask

   // Decide this cycle's retirements from the current head window and predict next-cycle outputs.
   task automatic model_step();
      int lanes[$];
      int nbr, mis, slot, l;
      bit stop, mp;
      ROB_ENTRY e;
      nbr = 0; mis = -1; slot = 0; stop = 1'b0;
      clear_expect();
      if (!m_halted && m_block == 0) begin
         for (int i = 0; i < N; i++) begin
            e = head_entries[i];
            if (!head_valids[i] || !e.complete) break;
            if (e.is_branch && nbr == TP) break;
            lanes.push_back(i);
            if (e.is_branch) nbr++;
            mp = e.is_branch && ((e.pred_taken != e.branch_taken) ||
                                 (e.branch_taken && (e.pred_target != e.branch_target)));
            if (mp) mis = i;
            if (e.halt || e.illegal) stop = 1'b1;
            if (stop || mp) break;
         end
      end
      e_pop = lanes.size();
      foreach (lanes[j]) begin
         l = lanes[j];
         e = head_entries[l];
         e_dbg[l].valid   = 1'b1;
         e_dbg[l].NPC     = e.pc + 32'd4;
         e_dbg[l].data    = regfile_entries[e.phys_rd];
         e_dbg[l].reg_idx = e.is_branch ? '0 : e.arch_rd;
         e_dbg[l].halt    = e.halt;
         e_dbg[l].illegal = e.illegal;
         if (e.is_branch) begin
            e_train[slot].valid      = 1'b1;
            e_train[slot].pc         = e.pc;
            e_train[slot].taken      = e.branch_taken;
            e_train[slot].target     = e.branch_target;
            e_train[slot].mispredict = (l == mis);
            slot++;
            e_btgt = e.branch_target;
         end else if (e.arch_rd != 0) begin
            e_we[l]    = 1'b1;
            e_addrs[l] = e.arch_rd;
            e_phys[l]  = e.phys_rd;
            m_ckpt[e.phys_rd] = 1'b0;
            if (e.prev_phys_rd != 0) begin
               e_free[e.prev_phys_rd] = 1'b1;
               m_ckpt[e.prev_phys_rd] = 1'b1;
            end
         end
      end
      if (e_pop > 0) e_restore = m_ckpt;
      m_cc = (m_cc + e_pop > CMAX) ? CMAX : m_cc + e_pop;
      if (mis >= 0) begin
         e_mispredict = 1'b1;
         e_idx        = head_idxs[mis];
         if (m_mc < CMAX) m_mc++;
      end
      if (m_block > 0) m_block--;
      else if (stop) m_halted = 1'b1;
      else if (mis >= 0) m_block = RC;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".mispredict"}, 512'(mispredict), 512'(e_mispredict));
      chk({tag, ".mis_idx"},    512'(rob_mispred_idx), 512'(e_idx));
      chk({tag, ".btgt"},       512'(branch_target_out), 512'(e_btgt));
      chk({tag, ".free"},       512'(free_mask), 512'(e_free));
      chk({tag, ".restore"},    512'(freelist_restore_mask), 512'(e_restore));
      chk({tag, ".we"},         512'(arch_write_enables), 512'(e_we));
      chk({tag, ".addrs"},      512'(arch_write_addrs), 512'(e_addrs));
      chk({tag, ".phys"},       512'(arch_write_phys_regs), 512'(e_phys));
      chk({tag, ".train"},      512'(train_req_o), 512'(e_train));
      chk({tag, ".dbg"},        512'(retire_commits_dbg), 512'(e_dbg));
      chk({tag, ".halted"},     512'(halted), 512'(m_halted));
      chk({tag, ".ccount"},     512'(commit_count), 512'(m_cc));
      chk({tag, ".mcount"},     512'(mispred_count), 512'(m_mc));
   endtask

   // Inputs are already applied; check the combinational pop, clock once, check registered outputs.
   task automatic step(input string tag, input int exp_pop);
      #1;
      model_step();
      chk({tag, ".pop"}, 512'(rob_pop_count), 512'(e_pop));
      if (exp_pop >= 0) chk({tag, ".pop_dir"}, 512'(rob_pop_count), 512'(exp_pop));
      @(posedge clock);
      #1;
      check_outputs(tag);
   endtask

   task automatic apply_reset(input string tag);
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs(tag);
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic all_alu(input int base);
      for (int i = 0; i < N; i++) begin
         head_entries[i] = alu(base + 4 * i, i + 1, 10 + i, 40 + i);
         head_idxs[i]    = ROB_IDX_W'(i);
      end
      head_valids = '1;
   endtask

   initial begin
      ROB_ENTRY h;
      head_entries = '0;
      head_valids  = '0;
      head_idxs    = '0;
      for (int i = 0; i < PR; i++) regfile_entries[i] = $urandom;
      apply_reset("por");

      // Full-width ALU retire frees the previous mappings.
      for (int i = 0; i < N; i++) head_entries[i] = alu(32'h100 + 4 * i, i + 1, 10 + i, 33 + i);
      head_valids = '1;
      step("alu4", 4);
      chk("alu4.free_bits", 512'(free_mask), 512'(64'h0000_001E_0000_0000));
      chk("alu4.count", 512'(commit_count), 512'(4));

      // Incomplete lane 1 ends the prefix; lane 2 is not retired.
      all_alu(32'h200);
      head_entries[1].complete = 1'b0;
      step("incomplete", 1);

      // Third branch exceeds the train ports.
      for (int i = 0; i < 3; i++) head_entries[i] = br(32'h300 + 4 * i, 1'b1, 32'h400 + i, 1'b1, 32'h400 + i);
      head_entries[3] = alu(32'h30C, 5, 20, 21);
      step("br3", 2);
      chk("br3.slot0", 512'(train_req_o[0].valid), 512'(1));
      chk("br3.slot1", 512'(train_req_o[1].valid), 512'(1));

      // Mispredict in lane 1, then exactly two stalled cycles.
      all_alu(32'h500);
      head_entries[1] = br(32'h504, 1'b1, 32'h800, 1'b0, 32'h800);
      head_idxs[1]    = 5'd9;
      step("mispred", 2);
      chk("mispred.flag", 512'(mispredict), 512'(1));
      chk("mispred.idx", 512'(rob_mispred_idx), 512'(9));
      all_alu(32'h600);
      step("recover1", 0);
      chk("recover1.flag_once", 512'(mispredict), 512'(0));
      step("recover2", 0);
      step("resume", 4);

      // Halt retires alone, then nothing retires until reset.
      all_alu(32'h700);
      h      = head_entries[0];
      h.halt = 1'b1;
      head_entries[0] = h;
      step("halt", 1);
      chk("halt.halted", 512'(halted), 512'(1));
      all_alu(32'h710);
      step("halted_idle", 0);
      apply_reset("halt_rst");
      for (int i = 0; i < N; i++) head_entries[i] = br(32'h900 + 4 * i, 1'b0, 0, 1'b0, 32'hA00 + i);
      step("post_rst", 2);
      chk("post_rst.ckpt", 512'(freelist_restore_mask), 512'(64'hFFFF_FFFF_0000_0000));

      // Drive the commit counter to its ceiling.
      for (int c = 0; c < 40 && m_cc < CMAX - 3; c++) begin
         all_alu(32'hB00 + 16 * c);
         step("fill", 4);
      end
      all_alu(32'hC00);
      step("sat", 4);
      chk("sat.count", 512'(commit_count), 512'(CMAX));

      // Randomized windows, with occasional resets (including mid-recovery and while halted).
      apply_reset("rand_rst");
      for (int c = 0; c < 400; c++) begin
         if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0) apply_reset("rnd_rst");
         for (int i = 0; i < N; i++) begin
            head_entries[i] = rnd_entry();
            head_idxs[i]    = ROB_IDX_W'($urandom);
            head_valids[i]  = ($urandom_range(0, 9) != 0);
         end
         step("rnd", -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/retire_unit_mw.md
RETIRE_UNIT_MW -- requirements
Module: retire_unit_mw

Interface
REQ-001 SHALL have parameter N, default `N, retire window width (oldest = lane 0).
REQ-002 SHALL have parameter PHYS_REGS, default `PHYS_REG_SZ_R10K, physical register count.
REQ-003 SHALL have parameter ARCH_REGS, default `ARCH_REG_SZ, architectural register count.
REQ-004 SHALL have parameter TRAIN_PORTS, default 2, maximum branches retired/trained per cycle (1..N).
REQ-005 SHALL have parameter RECOVER_CYCLES, default 2, recovery bubble length (>=1).
REQ-006 SHALL have parameter CNT_W, default 32, perf counter width.
REQ-007 SHALL have ports: clock in 1, the single clock; reset in 1, asynchronous active-low reset.
REQ-008 SHALL have inputs: head_entries in N x ROB_ENTRY; head_valids in N; head_idxs in N x ROB_IDX; regfile_entries in PHYS_REGS x DATA.
REQ-009 SHALL drive rob_pop_count, out $clog2(N+1), combinationally: entries committed this cycle.
REQ-010 SHALL drive these registered outputs: mispredict out 1; rob_mispred_idx out ROB_IDX; branch_target_out out ADDR; free_mask out PHYS_REGS; freelist_restore_mask out PHYS_REGS.
REQ-011 SHALL drive these registered outputs: arch_write_enables/addrs/phys_regs out N each; train_req_o out TRAIN_PORTS x BP_TRAIN_REQUEST; retire_commits_dbg out N x COMMIT_PACKET; halted out 1; commit_count and mispred_count out CNT_W each.

Function
REQ-012 SHALL select a commit prefix from lane 0 and end it at the first lane meeting any of these conditions: invalid; incomplete; (TRAIN_PORTS+1)th branch (both excluded); mispredicted branch; halt; ILLEGAL_INST (these three included).
REQ-013 SHALL define mispredict as pred_taken != branch_taken, or taken with pred_target != branch_target.
REQ-014 SHALL commit nothing while state is RECOVER or HALTED; rob_pop_count = 0 in those states.
REQ-015 SHALL present every side-effect output exactly one cycle after the commit decision (registered); all outputs are zero in any cycle with no commit.
REQ-016 SHALL, for each committed non-branch lane with arch_rd != 0, assert the arch write, clear phys_rd in the checkpoint, and, if prev_phys_rd != 0, set free_mask[prev_phys_rd] and the matching checkpoint bit.
REQ-017 SHALL apply checkpoint updates in lane order, so a later lane wins on a bit collision.
REQ-018 SHALL make freelist_restore_mask equal the checkpoint after the current cycle's updates.
REQ-019 SHALL fill train_req_o slots in lane order, one per committed branch, and set .mispredict on the mispredicted one; unused slots are invalid.
REQ-020 SHALL drive branch_target_out from the youngest committed branch.
REQ-021 SHALL drive mispredict and rob_mispred_idx (head_idxs of that lane) for exactly one cycle per mispredict.
REQ-022 SHALL have FSM states RUN, RECOVER, HALTED.
REQ-023 SHALL transition RUN->RECOVER on a committed mispredict, with a down-counter loaded with RECOVER_CYCLES; RECOVER->RUN when the counter hits 1; RECOVER lasts exactly RECOVER_CYCLES cycles.
REQ-024 SHALL transition RUN->HALTED on a committed halt or illegal instruction; HALTED is absorbing until reset; halted is asserted from the cycle after the transition.
REQ-025 SHALL increment commit_count by the commit count and mispred_count by 1 per mispredict; both saturate at all-ones.
REQ-026 SHALL fill retire_commits_dbg per committed lane: NPC = PC+4, data = regfile_entries[phys_rd], reg_idx = `ZERO_REG for branches, plus halt, illegal and valid.

Reset
REQ-027 SHALL, on reset low, asynchronously enter RUN, clear all registered outputs and counters, and load the checkpoint with the low ARCH_REGS bits 0 and the rest 1.
REQ-028 SHALL abort RECOVER and clear halted on reset mid-operation; the first commit is allowed on the first clock edge after release.

Structure
REQ-029 SHALL place the RETIRE_STATE enum and the mispredict-detect function in the shared sys_defs package; BP_TRAIN_REQUEST, ROB_ENTRY and COMMIT_PACKET remain shared.
REQ-030 SHALL isolate the prefix/branch-slot selection in a combinational sub-module retire_select.

Verification
REQ-031 SHALL cover: N=4, all lanes complete ALU, arch_rd 1..4, prev 33..36 -> pop 4; next cycle free_mask bits 33..36 set, commit_count=4.
REQ-032 SHALL cover: lane 1 incomplete -> pop 1; lane 2 ignored.
REQ-033 SHALL cover: TRAIN_PORTS=2, lanes 0-2 correct branches -> pop 2; train slots 0 and 1 valid.
REQ-034 SHALL cover: lane 1 mispredicted branch (idx 9) -> pop 2; next cycle mispredict=1, rob_mispred_idx=9; pop=0 for 2 cycles; commits resume on the third.
REQ-035 SHALL cover: halt in lane 0 -> pop 1, halted=1; later complete entries -> pop 0; reset low -> halted=0 with the checkpoint at its reset value.
REQ-036 SHALL cover: commit_count preset near all-ones then 4 commits -> saturates at all-ones.
